// File: rtl/clk_div_if.sv
// Bundle of the divider's enable input and its divided-clock outputs.
// The phase width follows the divider's ratio so both ends agree on it.
interface clk_div_if #(
    parameter int X = 8
);
    localparam int CW = (X > 2) ? $clog2(X) : 1;

    logic          en;
    logic          clk_divided;
    logic          tick;
    logic [CW-1:0] phase;

    modport master (output en, input clk_divided, input tick, input phase);
    modport slave  (input en, output clk_divided, output tick, output phase);
endinterface

// File: rtl/clk_div.sv
// Integer clock divider: registered divided clock with period X, a tick strobe
// on each rising edge of the divided clock, and the running phase count.
module clk_div #(
    parameter int X = 8
) (
    input  logic      clk,
    input  logic      rst,
    clk_div_if.slave  bus
);
    localparam int            CW     = (X > 2) ? $clog2(X) : 1;
    localparam logic [CW-1:0] HALF   = CW'(X / 2);
    localparam logic [CW-1:0] LAST   = CW'(X - 1);

    if (X < 2) begin : g_bad_ratio
        $error("clk_div: division ratio X must be at least 2");
    end

    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_next;
    logic          divided_q;
    logic          tick_q;

    always_comb begin
        phase_next = phase_q;
        if (bus.en) begin
            phase_next = (phase_q == LAST) ? '0 : phase_q + CW'(1);
        end
    end

    // With en low phase_next equals phase, so the divided clock naturally holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            divided_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            phase_q   <= phase_next;
            divided_q <= (phase_next >= HALF);
            tick_q    <= bus.en && (phase_next == HALF);
        end
    end

    assign bus.phase       = phase_q;
    assign bus.clk_divided = divided_q;
    assign bus.tick        = tick_q;
endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: four instances (X = 8, 5, 2, 3) on a shared clock,
// each with its own reset, checked against hand-derived phase/clock/tick values.
module tb_clk_div;
    logic clk;
    logic rst8, rst5, rst2, rst3;
    int   checks;
    int   errors;

    clk_div_if #(.X(8)) if8 ();
    clk_div_if #(.X(5)) if5 ();
    clk_div_if #(.X(2)) if2 ();
    clk_div_if #(.X(3)) if3 ();

    clk_div #(.X(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
    clk_div #(.X(5)) dut5 (.clk(clk), .rst(rst5), .bus(if5.slave));
    clk_div #(.X(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));
    clk_div #(.X(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst8   = 1'b1;
        if8.en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({if8.phase, if8.clk_divided, if8.tick} !== 5'b000_0_0) begin
                errors++;
                $display("[TB] FAIL reset8: phase=%0d div=%b tick=%b expected phase=0 div=0 tick=0",
                         if8.phase, if8.clk_divided, if8.tick);
            end
        end
        rst8 = 1'b0;
    endtask

    task automatic test_x8_count();
        logic [2:0] ep;
        logic       ed, et;
        int         ticks;
        ticks = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            ep = 3'(k % 8);
            ed = (k % 8) >= 4;
            et = (k % 8) == 4;
            if (if8.tick === 1'b1) ticks++;
            checks++;
            if ({if8.phase, if8.clk_divided, if8.tick} !== {ep, ed, et}) begin
                errors++;
                $display("[TB] FAIL x8_count edge %0d: phase=%0d div=%b tick=%b expected phase=%0d div=%b tick=%b",
                         k, if8.phase, if8.clk_divided, if8.tick, ep, ed, et);
            end
        end
        checks++;
        if (ticks !== 4) begin
            errors++;
            $display("[TB] FAIL x8_tick_count: got %0d expected 4", ticks);
        end
    endtask

    // Starts at phase 0: holds at phase 4 (tick must drop) and at phase 5.
    task automatic test_enable_hold();
        logic [2:0] seq_p [0:11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
        logic       seq_d [0:11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       seq_t [0:11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       seq_e [0:11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({if8.phase, if8.clk_divided, if8.tick} !== {seq_p[i], seq_d[i], seq_t[i]}) begin
                errors++;
                $display("[TB] FAIL enable_hold step %0d: phase=%0d div=%b tick=%b expected phase=%0d div=%b tick=%b",
                         i, if8.phase, if8.clk_divided, if8.tick, seq_p[i], seq_d[i], seq_t[i]);
            end
            if8.en = seq_e[i];
        end
    endtask

    task automatic test_midperiod_reset();
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        checks++;
        if (if8.phase !== 3'd6) begin
            errors++;
            $display("[TB] FAIL pre_reset_phase: phase=%0d expected 6", if8.phase);
        end
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        checks++;
        if ({if8.phase, if8.clk_divided, if8.tick} !== 5'b000_0_0) begin
            errors++;
            $display("[TB] FAIL midperiod_reset: phase=%0d div=%b tick=%b expected phase=0 div=0 tick=0",
                     if8.phase, if8.clk_divided, if8.tick);
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({if8.phase, if8.clk_divided, if8.tick} !== {3'(k), k == 4, k == 4}) begin
                errors++;
                $display("[TB] FAIL after_reset edge %0d: phase=%0d div=%b tick=%b expected phase=%0d div=%b tick=%b",
                         k, if8.phase, if8.clk_divided, if8.tick, k, k == 4, k == 4);
            end
        end
    endtask

    task automatic test_x5_odd();
        logic [2:0] ep;
        logic       ed, et;
        rst5   = 1'b1;
        if5.en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst5 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            ep = 3'(k % 5);
            ed = (k % 5) >= 2;
            et = (k % 5) == 2;
            checks++;
            if ({if5.phase, if5.clk_divided, if5.tick} !== {ep, ed, et}) begin
                errors++;
                $display("[TB] FAIL x5_odd edge %0d: phase=%0d div=%b tick=%b expected phase=%0d div=%b tick=%b",
                         k, if5.phase, if5.clk_divided, if5.tick, ep, ed, et);
            end
        end
    endtask

    task automatic test_x2_min();
        logic ep;
        rst2   = 1'b1;
        if2.en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            ep = (k % 2) == 1;
            checks++;
            if ({if2.phase, if2.clk_divided, if2.tick} !== {ep, ep, ep}) begin
                errors++;
                $display("[TB] FAIL x2_min edge %0d: phase=%0d div=%b tick=%b expected phase=%0d div=%b tick=%b",
                         k, if2.phase, if2.clk_divided, if2.tick, ep, ep, ep);
            end
        end
    endtask

    task automatic test_reset_priority();
        rst3   = 1'b1;
        if3.en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({if3.phase, if3.clk_divided, if3.tick} !== 4'b00_0_0) begin
                errors++;
                $display("[TB] FAIL reset_priority cycle %0d: phase=%0d div=%b tick=%b expected phase=0 div=0 tick=0",
                         c, if3.phase, if3.clk_divided, if3.tick);
            end
        end
        rst3   = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if3.phase !== 2'd1) begin
            errors++;
            $display("[TB] FAIL x3_release: phase=%0d expected 1", if3.phase);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst8 = 1'b1; rst5 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        if8.en = 1'b0; if5.en = 1'b0; if2.en = 1'b0; if3.en = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_x8_count();
        test_enable_hold();
        test_midperiod_reset();
        test_x5_odd();
        test_x2_min();
        test_reset_priority();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
